// File: rtl/router_ctrl_if.sv
// Byte-stream and FIFO-side signals of the 1x3 router controller.
// master = source/FIFO side, slave = router_ctrl.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] rd_en;
  logic       busy;
  logic [2:0] wr_en;
  logic [7:0] fifo_data;
  logic       err;
  logic       pkt_done;
  logic       drop;
  logic [2:0] soft_rst;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, rd_en,
    input  busy, wr_en, fifo_data, err, pkt_done, drop, soft_rst
  );
  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, rd_en,
    output busy, wr_en, fifo_data, err, pkt_done, drop, soft_rst
  );
endinterface

// File: rtl/router_ctrl.sv
// 1x3 router packet controller: header decode, FIFO steering, parity check, drop.
// ROUTER_CTRL_TIMEOUT_EN builds per-output stall timers, soft_rst and the abort path.

module router_ctrl_timer #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic soft_rst_q
);
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          soft_rst_d;

  always_comb begin
    timer_d    = '0;
    soft_rst_d = 1'b0;
    if (stall) begin
      if (timer_q == TW'(TIMEOUT - 1)) soft_rst_d = 1'b1;
      else                             timer_d    = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      soft_rst_q <= soft_rst_d;
    end
  end
endmodule

module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input logic        clk,
  input logic        rst,
  router_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, PARITY, DROP} state_t;

  state_t     state_q, state_d;
  logic [1:0] dest_q, dest_d;
  logic [5:0] cnt_q, cnt_d;
  logic [6:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] par_q, par_d;
  logic       err_q, err_d;
  logic       pkt_done_q, pkt_done_d;
  logic       drop_q, drop_d;
  logic       busy;
  logic [2:0] wr_en;
  logic [2:0] soft_rst;
  logic       abort;
  logic [5:0] hdr_len;
  logic [1:0] hdr_addr;

  assign hdr_len  = bus.data_in[7:2];
  assign hdr_addr = bus.data_in[1:0];

`ifdef ROUTER_CTRL_TIMEOUT_EN
  logic [2:0] stall;
  assign stall = ~bus.fifo_empty & ~bus.rd_en;

  router_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_tmr [2:0] (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .soft_rst_q (soft_rst)
  );

  // A stalled consumer on the packet's own output kills the packet in flight.
  assign abort = ((state_q == LOAD) || (state_q == PARITY)) && soft_rst[dest_q];
`else
  logic unused_tmr;
  assign unused_tmr = ^{bus.rd_en, TIMEOUT[0]};
  assign soft_rst   = 3'b000;
  assign abort      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    par_d      = par_q;
    err_d      = err_q;
    pkt_done_d = 1'b0;
    drop_d     = 1'b0;
    busy       = 1'b0;
    wr_en      = 3'b000;
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          if (hdr_addr == 2'd3) begin
            drop_cnt_d = {1'b0, hdr_len} + 7'd1;
            state_d    = DROP;
          end else if (!bus.fifo_empty[hdr_addr]) begin
            busy = 1'b1;
          end else begin
            wr_en[hdr_addr] = 1'b1;
            dest_d          = hdr_addr;
            cnt_d           = hdr_len;
            par_d           = bus.data_in;
            state_d         = (hdr_len != 6'd0) ? LOAD : PARITY;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          busy       = 1'b1;
          drop_cnt_d = {1'b0, cnt_q} + 7'd1;
          state_d    = DROP;
        end else if (bus.fifo_full[dest_q]) begin
          busy = 1'b1;
        end else if (bus.pkt_valid) begin
          wr_en[dest_q] = 1'b1;
          par_d         = par_q ^ bus.data_in;
          cnt_d         = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = PARITY;
        end
      end
      PARITY: begin
        if (abort) begin
          busy       = 1'b1;
          drop_cnt_d = 7'd1;
          state_d    = DROP;
        end else if (bus.fifo_full[dest_q]) begin
          busy = 1'b1;
        end else if (bus.pkt_valid) begin
          wr_en[dest_q] = 1'b1;
          err_d         = (par_q != bus.data_in);
          pkt_done_d    = 1'b1;
          state_d       = IDLE;
        end
      end
      DROP: begin
        if (bus.pkt_valid) begin
          drop_cnt_d = drop_cnt_q - 7'd1;
          if (drop_cnt_q == 7'd1) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= 2'd0;
      cnt_q      <= 6'd0;
      drop_cnt_q <= 7'd0;
      par_q      <= 8'd0;
      err_q      <= 1'b0;
      pkt_done_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      par_q      <= par_d;
      err_q      <= err_d;
      pkt_done_q <= pkt_done_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.wr_en     = wr_en;
  assign bus.fifo_data = bus.data_in;
  assign bus.err       = err_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.drop      = drop_q;
  assign bus.soft_rst  = soft_rst;
endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: vector table, corner sequences, and
// randomized packets against a packet-level reference model.
module tb_router_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_ctrl_if bus();
  router_ctrl #(.TIMEOUT(30)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] f,
                       input logic [2:0] e, input logic [2:0] r);
    @(negedge clk);
    bus.pkt_valid  = v;
    bus.data_in    = d;
    bus.fifo_full  = f;
    bus.fifo_empty = e;
    bus.rd_en      = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] full;
    logic [2:0] empty;
    logic       busy;
    logic [2:0] wr;
    logic       done;
    logic       drp;
    logic       err;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic [2:0] f, logic [2:0] e,
                              logic b, logic [2:0] w, logic dn, logic dr, logic er);
    vec_t t;
    t.v = v; t.d = d; t.full = f; t.empty = e;
    t.busy = b; t.wr = w; t.done = dn; t.drp = dr; t.err = er;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    int pulses, pulse_at;

    // routed packet, L=3 to FIFO 1
    tbl.push_back(mk(1, 8'h0D, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h11, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h33, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h0D, 3'b000, 3'b111, 0, 3'b010, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 3'b000, 3'b111, 0, 3'b000, 0, 0, 0));
    // same packet, bad parity
    tbl.push_back(mk(1, 8'h0D, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h11, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h33, 3'b000, 3'b111, 0, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 3'b000, 3'b111, 0, 3'b010, 1, 0, 1));
    // invalid address, back to back; err must hold
    tbl.push_back(mk(1, 8'h07, 3'b000, 3'b111, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(1, 8'hAA, 3'b000, 3'b111, 0, 3'b000, 0, 0, 1));
    tbl.push_back(mk(1, 8'hAD, 3'b000, 3'b111, 0, 3'b000, 0, 1, 1));
    // zero length to FIFO 2
    tbl.push_back(mk(1, 8'h02, 3'b000, 3'b111, 0, 3'b100, 0, 0, 1));
    tbl.push_back(mk(1, 8'h02, 3'b000, 3'b111, 0, 3'b100, 1, 0, 0));
    // empty gate on FIFO 0, then full backpressure mid-payload
    tbl.push_back(mk(1, 8'h08, 3'b000, 3'b110, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 8'h08, 3'b000, 3'b110, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 8'h08, 3'b000, 3'b111, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h55, 3'b001, 3'b111, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 8'h55, 3'b001, 3'b111, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 8'h55, 3'b000, 3'b111, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h66, 3'b000, 3'b111, 0, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h3B, 3'b000, 3'b111, 0, 3'b001, 1, 0, 0));

    // reset
    rst = 1'b1;
    drive(0, 8'h00, 3'b000, 3'b111, 3'b111);
    tick();
    tick();
    chk("rst.busy", bus.busy, 0);
    chk("rst.wr_en", bus.wr_en, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.pkt_done", bus.pkt_done, 0);
    chk("rst.drop", bus.drop, 0);
    chk("rst.soft_rst", bus.soft_rst, 0);
    drive(0, 8'h00, 3'b000, 3'b111, 3'b111);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].full, tbl[i].empty, 3'b111);
      chk($sformatf("tbl[%0d].busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("tbl[%0d].wr_en", i), bus.wr_en, tbl[i].wr);
      chk($sformatf("tbl[%0d].fifo_data", i), bus.fifo_data, tbl[i].d);
      tick();
      chk($sformatf("tbl[%0d].pkt_done", i), bus.pkt_done, tbl[i].done);
      chk($sformatf("tbl[%0d].drop", i), bus.drop, tbl[i].drp);
      chk($sformatf("tbl[%0d].err", i), bus.err, tbl[i].err);
    end

    // reset mid-packet: abandoned silently, next header decoded from IDLE
    drive(1, 8'h0D, 3'b000, 3'b111, 3'b111);
    chk("mid_rst.hdr_wr", bus.wr_en, 3'b010);
    tick();
    drive(1, 8'h11, 3'b000, 3'b111, 3'b111);
    tick();
    drive(0, 8'h22, 3'b000, 3'b111, 3'b111);
    rst = 1'b1;
    tick();
    chk("mid_rst.done", bus.pkt_done, 0);
    chk("mid_rst.drop", bus.drop, 0);
    drive(1, 8'h0A, 3'b000, 3'b111, 3'b111);
    rst = 1'b0;
    chk("mid_rst.new_hdr_wr", bus.wr_en, 3'b100);
    chk("mid_rst.new_hdr_busy", bus.busy, 0);
    tick();
    chk("mid_rst.no_drop", bus.drop, 0);
    drive(1, 8'h01, 3'b000, 3'b111, 3'b111);
    tick();
    drive(1, 8'h02, 3'b000, 3'b111, 3'b111);
    tick();
    drive(1, 8'h09, 3'b000, 3'b111, 3'b111);
    chk("mid_rst.par_wr", bus.wr_en, 3'b100);
    tick();
    chk("mid_rst.done_after", bus.pkt_done, 1);
    chk("mid_rst.err_after", bus.err, 0);

`ifdef ROUTER_CTRL_TIMEOUT_EN
    // idle stall on output 1: exactly one soft reset after 30 stalled cycles
    pulses = 0;
    pulse_at = -1;
    for (int c = 0; c < 34; c++) begin
      drive(0, 8'h00, 3'b000, (c < 32) ? 3'b101 : 3'b111, 3'b000);
      tick();
      if (bus.soft_rst[1]) begin
        pulses++;
        pulse_at = c;
      end
      if (bus.soft_rst[0] || bus.soft_rst[2]) pulses += 100;
    end
    chk("tmo.idle_pulses", pulses, 1);
    chk("tmo.idle_pulse_at", pulse_at, 29);

    // stall mid-LOAD with 2 payload bytes left: remaining 3 bytes drained
    drive(1, 8'h0D, 3'b000, 3'b111, 3'b111);
    tick();
    drive(1, 8'h11, 3'b000, 3'b111, 3'b111);
    tick();
    for (int c = 0; c < 30; c++) begin
      drive(0, 8'h22, 3'b000, 3'b101, 3'b000);
      tick();
    end
    chk("tmo.load_soft_rst", bus.soft_rst, 3'b010);
    drive(1, 8'h22, 3'b000, 3'b111, 3'b111);
    chk("tmo.abort_busy", bus.busy, 1);
    chk("tmo.abort_wr", bus.wr_en, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h22 + 8'(k * 17), 3'b000, 3'b111, 3'b111);
      chk($sformatf("tmo.drain%0d.busy", k), bus.busy, 0);
      chk($sformatf("tmo.drain%0d.wr", k), bus.wr_en, 0);
      tick();
      chk($sformatf("tmo.drain%0d.drop", k), bus.drop, (k == 2));
      chk($sformatf("tmo.drain%0d.done", k), bus.pkt_done, 0);
    end
`else
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 8'h00, 3'b000, 3'b000, 3'b000);
      tick();
      if (bus.soft_rst != 3'b000) pulses++;
    end
    chk("notmo.soft_rst_pulses", pulses, 0);
`endif

    // randomized packets against a packet-level model
    rst = 1'b1;
    drive(0, 8'h00, 3'b000, 3'b111, 3'b111);
    tick();
    drive(0, 8'h00, 3'b000, 3'b111, 3'b111);
    rst = 1'b0;
    tick();
    begin
      logic exp_err;
      exp_err = 1'b0;
      for (int p = 0; p < 40; p++) begin
        int addr, len, total, pos, cyc;
        logic [7:0] bytes[$];
        logic [7:0] par;
        addr  = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 2);
        len   = $urandom_range(0, 7);
        total = len + 2;
        bytes = {};
        bytes.push_back({6'(len), 2'(addr)});
        par = bytes[0];
        for (int j = 0; j < len; j++) begin
          bytes.push_back(8'($urandom_range(0, 255)));
          par ^= bytes[j + 1];
        end
        if ($urandom_range(0, 3) == 0) bytes.push_back(par ^ 8'($urandom_range(1, 255)));
        else                           bytes.push_back(par);
        pos = 0;
        cyc = 0;
        while (pos < total && cyc < 200) begin
          logic v, exp_busy, acc, last;
          logic [2:0] f, e, exp_wr;
          v = ($urandom_range(0, 3) != 0);
          for (int b = 0; b < 3; b++) begin
            f[b] = ($urandom_range(0, 3) == 0);
            e[b] = ($urandom_range(0, 3) != 0);
          end
          drive(v, bytes[pos], f, e, 3'b111);
          if (pos == 0)       exp_busy = v && (addr != 3) && !e[addr];
          else if (addr == 3) exp_busy = 1'b0;
          else                exp_busy = f[addr];
          acc    = v && !exp_busy;
          exp_wr = (acc && addr != 3) ? 3'(1 << addr) : 3'b000;
          chk($sformatf("rnd%0d.busy", p), bus.busy, exp_busy);
          chk($sformatf("rnd%0d.wr_en", p), bus.wr_en, exp_wr);
          chk($sformatf("rnd%0d.fifo_data", p), bus.fifo_data, bytes[pos]);
          last = acc && (pos == total - 1);
          if (acc) pos++;
          tick();
          if (last && addr != 3) exp_err = (bytes[total - 1] != par);
          chk($sformatf("rnd%0d.pkt_done", p), bus.pkt_done, last && (addr != 3));
          chk($sformatf("rnd%0d.drop", p), bus.drop, last && (addr == 3));
          chk($sformatf("rnd%0d.err", p), bus.err, exp_err);
          cyc++;
        end
        chk($sformatf("rnd%0d.completed", p), pos, total);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet controller for the 1x3 router. It accepts a byte stream from the single input port, decodes each packet's header and steers the packet into one of the three output FIFOs by driving their write enables. It checks packet parity, discards packets with an invalid address, and soft-resets any output FIFO whose consumer stalls too long. It sits between the input port and the three FIFO instances.

## Interface
- TIMEOUT, 30: consecutive stalled cycles before an output's soft reset fires.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_valid  in  1  data_in holds a valid byte.
- data_in  in  8  packet byte.
- fifo_full  in  3  full flag of FIFO i.
- fifo_empty  in  3  empty flag of FIFO i.
- rd_en  in  3  read enable of FIFO i, observed for the timeout.
- busy  out  1  source must hold the current byte; combinational.
- wr_en  out  3  one-hot write enable to FIFO i; combinational.
- fifo_data  out  8  FIFO write data; equals data_in.
- err  out  1  parity mismatch on the last packet; registered.
- pkt_done  out  1  one-cycle pulse, packet fully written.
- drop  out  1  one-cycle pulse, packet discarded.
- soft_rst  out  3  one-cycle soft reset for FIFO i; registered.

## Operation
- Packet format:
  - Header byte: [7:2] payload length L (0..63), [1:0] address (0..2 valid, 3 invalid).
  - Then L payload bytes.
  - Then one parity byte: the XOR of the header and all payload bytes.
- A byte is accepted when pkt_valid=1 and busy=0. Every accepted byte of a routed packet is written that same cycle: wr_en[dest]=1.
- The controller has four states: IDLE, LOAD, PARITY, DROP.
- IDLE:
  - addr=3: the header is accepted with no write. drop_cnt<=L+1 (bytes left to discard); go to DROP.
  - addr valid: ready only when fifo_empty[addr]=1. On accept: dest<=addr, cnt<=L, par<=data_in; go to LOAD if L>0, else PARITY.
- LOAD:
  - Ready when fifo_full[dest]=0.
  - On accept: par^=data_in, cnt--. When cnt==1, go to PARITY.
- PARITY:
  - Ready when fifo_full[dest]=0.
  - On accept: the byte is written, err<=(par!=data_in), pkt_done pulses next cycle, go to IDLE.
- DROP:
  - Always ready, never writes.
  - Each accept decrements drop_cnt. On the accept at drop_cnt==1: drop pulses next cycle, go to IDLE.
- busy=1 whenever the current state is not ready. This includes pkt_valid=0 in a not-ready state, so busy is independent of pkt_valid except in IDLE.
- Timeout, per output i:
  - timer[i] increments on cycles with fifo_empty[i]=0 and rd_en[i]=0, and clears otherwise.
  - When it reaches TIMEOUT-1 and the condition still holds, soft_rst[i]<=1 for one cycle and timer[i]<=0.
  - Timer width is $clog2(TIMEOUT)+1.
- Abort:
  - soft_rst[dest]=1 in LOAD or PARITY forces busy=1 that cycle.
  - Next state is DROP with drop_cnt = bytes remaining: cnt+1 from LOAD, 1 from PARITY.
  - pkt_done does not fire; drop does fire at the end of the drain.
- Priority: rst > abort > byte accept.
- err holds its value until the next parity check or reset.

## Timing
- Reset: state=IDLE, all counters=0, err=0, pkt_done=0, drop=0, soft_rst=3'b000. The combinational outputs are then wr_en=0, and busy follows the IDLE rule.
- Reset mid-packet abandons the packet silently: no drop, no pkt_done.
- Latency:
  - Write: 0 cycles from accept.
  - err, pkt_done, drop: 1 cycle after the final accept.
- Full FIFO: no write and busy=1 until fifo_full clears. The byte is not lost; the source holds it.
- A packet of length L into a non-full FIFO takes L+2 accept cycles.
- A new header may be accepted in the cycle after the parity or last dropped byte, subject to the empty check.
- soft_rst[i] for i != dest does not affect the packet in flight.

## Configuration
- ROUTER_CTRL_TIMEOUT_EN defined: the timers, soft_rst and the abort path are present as above.
- Not defined: no timer logic is built, soft_rst is tied to 3'b000, and the abort path is absent.

## Test plan
- Routed packet: header 8'h0D (L=3, addr 1), then 8'h11, 8'h22, 8'h33, parity 8'h0D. Required: 5 writes with wr_en=3'b010, then err=0 and one pkt_done pulse.
- Parity error: same packet with parity 8'h00. Required: err=1 one cycle after the parity accept; all 5 bytes still written.
- Invalid address: header 8'h07 (L=1, addr 3), then 8'hAA, 8'hAD. Required: 3 accepts, wr_en=0 throughout, one drop pulse, return to IDLE.
- Empty gate and backpressure:
  - fifo_empty[0]=0 with header 8'h08 pending. Required: busy=1 until fifo_empty[0]=1.
  - fifo_full[0]=1 mid-payload. Required: busy=1, wr_en=0, data held.
- Zero length: header 8'h02 then parity 8'h02. Required: 2 writes on FIFO 2, err=0.
- Timeout (macro on, TIMEOUT=30):
  - fifo_empty[1]=0 and rd_en[1]=0 for 30 cycles. Required: soft_rst[1] pulses once.
  - Same timeout mid-LOAD to FIFO 1 with 2 payload bytes left. Required: the remaining 3 bytes are drained unwritten, then a drop pulse.
